pool_collector: RTL and testbench

- Receive end of the pooler output stream: captures the `valid_op` / `data_out` / `end_op` pooled words into an internal OUT_DIM x OUT_DIM buffer, in raster order.
- Signals completion to the layer controller.
- Exposes a registered random-access read port so the next layer (or the bench) can fetch the pooled feature map.

---
 rtl/pool_collector.sv | 139 +++++++++++++
 tb/tb_pool_collector.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pool_collector.sv
// Receive end of the pooler stream: stores pooled words in raster order into an
// OUT_DIM x OUT_DIM buffer, flags completion, and serves a registered read port.
module pool_collector #(
  parameter logic [8:0] M  = 9'h4,
  parameter logic [8:0] P  = 9'h2,
  parameter int         DW = 32,
  parameter int         AW = 4
) (
  input  logic          clk,
  input  logic          master_rst,
  input  logic          ce,
  input  logic          valid_in,
  input  logic [DW-1:0] data_in,
  input  logic          end_in,
  input  logic          clear,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          done,
  output logic          short_map,
  output logic          overflow
);

  localparam int OUT_DIM = int'(M) / int'(P);
  localparam int DEPTH   = OUT_DIM * OUT_DIM;
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] COL_LAST  = AW'(OUT_DIM - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t        state_q;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] col_q, col_d;
  logic          done_q, short_q, ovf_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic          wr_en;

  logic [DW-1:0] mem_q [2**AW];

  // A word is accepted only while collecting and not full; clear and reset drop it.
  assign wr_en = ce && !master_rst && !clear && valid_in &&
                 (state_q != DONE) && (count_q < CNT_DEPTH);

  always_comb begin
    count_d = count_q + 1'b1;
    row_d   = row_q;
    col_d   = col_q + 1'b1;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (master_rst) begin
      state_q <= IDLE;
      count_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (ce) begin
      if (clear) begin
        state_q <= IDLE;
        count_q <= '0;
        row_q   <= '0;
        col_q   <= '0;
        done_q  <= 1'b0;
        short_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE, COLLECT: begin
            if (wr_en) begin
              count_q <= count_d;
              row_q   <= row_d;
              col_q   <= col_d;
              // Final write completes normally even with a coincident end_in.
              if (count_d == CNT_DEPTH) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else if (end_in) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                short_q <= 1'b1;
              end else begin
                state_q <= COLLECT;
              end
            end else if (valid_in) begin
              ovf_q <= 1'b1;
            end else if (end_in) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              short_q <= 1'b1;
            end
          end
          DONE: begin
            if (valid_in) ovf_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Buffer has no reset; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[count_q[AW-1:0]] <= data_in;
  end

  // Read port ignores ce and state; nonblocking update gives read-before-write.
  always_ff @(posedge clk) begin
    if (master_rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en)
        rd_data_q <= ({1'b0, rd_addr} < CNT_DEPTH) ? mem_q[rd_addr] : '0;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign row       = row_q;
  assign col       = col_q;
  assign done      = done_q;
  assign short_map = short_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pool_collector.sv
// Directed bench for pool_collector; read results are checked against a queue
// of expected words filled when each read request is driven.
module tb_pool_collector;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          master_rst, ce, valid_in, end_in, clear, rd_en;
  logic [DW-1:0] data_in;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic [AW-1:0] row, col;
  logic          done, short_map, overflow;

  int nvec = 0;
  int nerr = 0;
  logic [DW-1:0] exp_q[$];

  pool_collector #(.M(9'h4), .P(9'h2), .DW(DW), .AW(AW)) dut (
    .clk(clk), .master_rst(master_rst), .ce(ce), .valid_in(valid_in),
    .data_in(data_in), .end_in(end_in), .clear(clear), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .row(row), .col(col), .done(done), .short_map(short_map), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic e);
    valid_in = 1'b1; data_in = d; end_in = e;
    tick();
    valid_in = 1'b0; end_in = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd_en = 1'b1; rd_addr = a; exp_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  // Scoreboard: every rd_valid consumes one expected word.
  always @(posedge clk) begin
    #1;
    if (rd_valid) begin
      if (exp_q.size() == 0) chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
      else chk("rd_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic drain();
    tick(); tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    master_rst = 1'b1; ce = 1'b1; valid_in = 1'b0; end_in = 1'b0; clear = 1'b0;
    rd_en = 1'b0; rd_addr = '0; data_in = '0;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_rowcol", {row, col}, 0);
    chk("rst_flags", {done, short_map, overflow, rd_valid}, 0);
    chk("rst_rd_data", rd_data, 0);
    master_rst = 1'b0;

    // Back-to-back map with end_in on the last word
    send(5, 0); send(7, 0); send(13, 0);
    chk("m1_not_done", 32'(done), 0);
    send(15, 1);
    chk("m1_done", 32'(done), 1);
    chk("m1_count", 32'(count), 4);
    chk("m1_short", 32'(short_map), 0);
    rd(0, 5); rd(1, 7); rd(2, 13); rd(3, 15);
    drain();

    // Overflow in DONE, then clear
    send(32'hDEAD, 0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 4);
    rd(3, 15);
    drain();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_flags", {done, short_map, overflow}, 0);
    chk("clr_count", 32'(count), 0);

    // Gapped stream with ce dropped mid-map
    send(1, 0);
    chk("gap_rc1", {row, col}, {4'd0, 4'd1});
    tick(); tick();
    send(2, 0);
    chk("gap_rc2", {row, col}, {4'd1, 4'd0});
    ce = 1'b0; valid_in = 1'b1; data_in = 99; end_in = 1'b1;
    tick(); tick(); tick();
    valid_in = 1'b0; end_in = 1'b0; ce = 1'b1;
    chk("gap_ce_hold", 32'(count), 2);
    chk("gap_ce_nodone", 32'(done), 0);
    send(3, 0);
    chk("gap_rc3", {row, col}, {4'd1, 4'd1});
    tick(); tick();
    send(4, 0);
    chk("gap_done", {done, short_map}, 2'b10);
    rd(0, 1); rd(1, 2); rd(2, 3); rd(3, 4);
    drain();
    clear = 1'b1; tick(); clear = 1'b0;

    // Early end
    send(9, 0); send(10, 0);
    end_in = 1'b1; tick(); end_in = 1'b0;
    chk("early_done", 32'(done), 1);
    chk("early_short", 32'(short_map), 1);
    chk("early_count", 32'(count), 2);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("early_clr", {done, short_map, 27'd0, count}, 0);

    // Second map; read addr 0 while it is being written returns the old word
    rd_en = 1'b1; rd_addr = 0; exp_q.push_back(9);
    send(20, 0);
    rd_en = 1'b0;
    send(21, 0); send(22, 0); send(23, 0);
    chk("m2_done_count", {done, 27'd0, count}, {1'b1, 27'd0, 5'd4});
    rd(0, 20); rd(1, 21); rd(2, 22); rd(3, 23); rd(7, 0);
    drain();

    // Clear coincident with valid: word dropped, no overflow
    clear = 1'b1; valid_in = 1'b1; data_in = 77; tick();
    clear = 1'b0; valid_in = 1'b0;
    chk("clrv_state", {done, overflow, 27'd0, count}, 0);

    // Mid-map reset, then a full map
    send(40, 0); send(41, 0);
    master_rst = 1'b1; tick(); master_rst = 1'b0;
    chk("mrst_outs", {done, short_map, overflow, rd_valid, 23'd0, count}, 0);
    chk("mrst_rowcol", {row, col}, 0);
    send(31, 0); send(32, 0); send(33, 0); send(34, 0);
    chk("m3_done_count", {done, short_map, 26'd0, count}, {2'b10, 26'd0, 5'd4});
    rd(2, 33);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
